phi_t_collect: RTL
==================

PHI_T_COLLECT -- requirements
Module: phi_t_collect

Interface
REQ-001 SHALL have parameter DW, default 64, meaning result word width in bits (IEEE-754 double).
REQ-002 SHALL have parameter DEPTH, default 16, meaning result FIFO entries (power of two).
REQ-003 SHALL have parameter LW, default 16, meaning frame-length counter width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  meaning copy of the start pulse issued to the upstream phi_t stage, one pulse per operand pair.
REQ-007 SHALL have port phi_t  input  DW  meaning result from phi_t stage.
REQ-008 SHALL have port phi_t_vld  input  1  meaning phi_t valid; no backpressure is possible upstream.
REQ-009 SHALL have port credit_ok  output  1  meaning safe to issue another start_i.
REQ-010 SHALL have port frame_go  input  1  meaning one-cycle pulse that begins a frame.
REQ-011 SHALL have port frame_len  input  LW  meaning results in the frame, sampled on frame_go.
REQ-012 SHALL have port m_tdata  output  DW  meaning result to downstream consumer.
REQ-013 SHALL have port m_tvalid  output  1  meaning m_tdata valid.
REQ-014 SHALL have port m_tready  input  1  meaning downstream accepts.
REQ-015 SHALL have port m_tlast  output  1  meaning final result of frame.
REQ-016 SHALL have port done  output  1  meaning one-cycle pulse at frame end.
REQ-017 SHALL have port overflow  output  1  meaning sticky: a result was dropped.

Function
REQ-018 SHALL write phi_t into the FIFO on any cycle with phi_t_vld=1 and (not full, or a read occurs that cycle).
REQ-019 SHALL drop phi_t and set overflow when phi_t_vld=1, FIFO full and no read that cycle.
REQ-020 SHALL keep inflight count (0..DEPTH): +1 on start_i, -1 on phi_t_vld, unchanged when both occur in one cycle.
REQ-021 SHALL drive credit_ok combinationally = (occupancy + inflight) < DEPTH.
REQ-022 SHALL implement states IDLE, RUN, LAST_DONE; IDLE on reset.
REQ-023 SHALL, in IDLE on frame_go with frame_len>0, load frame_len, clear output index and overflow, enter RUN.
REQ-024 SHALL, in IDLE on frame_go with frame_len=0, clear overflow, pulse done next cycle, stay IDLE, emit nothing.
REQ-025 SHALL ignore frame_go outside IDLE.
REQ-026 SHALL assert m_tvalid only in RUN with FIFO non-empty; data arriving in IDLE is retained until RUN.
REQ-027 SHALL present FIFO head on m_tdata (first-word fall-through; zero-cycle head-to-output latency).
REQ-028 SHALL hold m_tdata/m_tvalid stable while m_tvalid=1 and m_tready=0.
REQ-029 SHALL assert m_tlast with m_tvalid when output index = frame_len-1.
REQ-030 SHALL, on accepted beat with m_tlast, go to LAST_DONE, pulse done for exactly one cycle, then return to IDLE.
REQ-031 SHALL give end-to-end latency of one cycle: phi_t_vld at cycle N makes m_tvalid high at cycle N+1 (RUN, FIFO previously empty).
REQ-032 SHALL wrap FIFO pointers modulo DEPTH using log2(DEPTH)+1-bit pointers for full/empty.
REQ-033 SHALL saturate inflight at 0 on unmatched phi_t_vld and at DEPTH on excess start_i.

Reset
REQ-034 SHALL on rst: state IDLE, FIFO empty, inflight 0, index 0, m_tvalid 0, m_tlast 0, done 0, overflow 0, credit_ok 1, m_tdata 0.
REQ-035 SHALL on rst mid-frame discard all stored and in-flight results with no done pulse.

Structure
REQ-036 SHALL take DW, DEPTH default, LW and the state enum from shared package phi_pkg.
REQ-037 SHALL instantiate one sub-module phi_fifo (synchronous FWFT FIFO, occupancy output); control, counters and FSM in top.

Verification
REQ-038 SHALL cover: frame_len=3, three phi_t 0xC000000000000000/0xBFF0000000000000/0x8000000000000000, m_tready=1 -> three beats in order, m_tlast on third, done one cycle after.
REQ-039 SHALL cover: 16 results while m_tready=0 then a 17th -> overflow=1, first 16 delivered intact, 17th absent.
REQ-040 SHALL cover: 10 start_i pulses, no results, FIFO holding 6 -> credit_ok=0; one result returns and one read -> credit_ok=1.
REQ-041 SHALL cover: frame_go with frame_len=0 -> no m_tvalid, done high exactly one cycle later.
REQ-042 SHALL cover: m_tready toggling 1/0 each cycle over frame_len=5 -> all five beats, stable data during stalls, one done.
REQ-043 SHALL cover: rst asserted after 2 of 4 beats -> all outputs at reset values immediately, no done, next frame unaffected.

Source files
------------

// File: rtl/phi_pkg.sv
// Shared sizing defaults and FSM state encoding for the phi_t result collector.
package phi_pkg;

  localparam int PHI_DW    = 64;  // IEEE-754 double result word
  localparam int PHI_DEPTH = 16;  // result FIFO entries, power of two
  localparam int PHI_LW    = 16;  // frame-length counter width

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LAST_DONE = 2'd2
  } phi_state_e;

endpackage

// File: rtl/phi_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible on
// rd_data_o, so a read simply advances the pointer. Pointers carry one extra
// wrap bit to distinguish full from empty.
module phi_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_wr;
  logic          do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A write into a full FIFO is only legal when the head leaves the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  // Storage array; contents need no reset because empty gates their use.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Read and write pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/phi_t_collect.sv
// Collects phi_t results from a non-stallable upstream stage into a FIFO,
// tracks outstanding requests for start credit, and streams framed results
// downstream with last/done marking.
//
//   state     | meaning
//   IDLE      | waiting for frame_go; arriving results are buffered, not sent
//   RUN       | streaming buffered results until the frame's last beat
//   LAST_DONE | last beat accepted; done is high for this single cycle
module phi_t_collect
  import phi_pkg::*;
#(
  parameter int DW    = PHI_DW,
  parameter int DEPTH = PHI_DEPTH,
  parameter int LW    = PHI_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] phi_t,
  input  logic          phi_t_vld,
  output logic          credit_ok,
  input  logic          frame_go,
  input  logic [LW-1:0] frame_len,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          done,
  output logic          overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  phi_state_e    state_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic          done_q;
  logic          overflow_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;

  logic [DW-1:0] fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  logic          last_beat;
  logic [CW:0]   pending;

  phi_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (phi_t),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  // Upstream cannot be stalled: a result that finds the FIFO full with no
  // simultaneous read is lost and flagged.
  assign rd_en = m_tvalid & m_tready;
  assign wr_en = phi_t_vld & (~fifo_full | rd_en);
  assign drop  = phi_t_vld & fifo_full & ~rd_en;

  assign last_beat = (idx_q == len_q - 1'b1);
  assign m_tvalid  = (state_q == RUN) & ~fifo_empty;
  assign m_tlast   = m_tvalid & last_beat;
  assign m_tdata   = m_tvalid ? fifo_head : '0;
  assign done      = done_q;
  assign overflow  = overflow_q;

  // Credit counts both buffered results and results still owed by upstream.
  assign pending   = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok = (pending < (CW+1)'(DEPTH));

  // Outstanding-request count, saturating at 0 and DEPTH.
  always_comb begin
    inflight_d = inflight_q;
    if (start_i && !phi_t_vld) begin
      if (inflight_q != CW'(DEPTH)) inflight_d = inflight_q + 1'b1;
    end else if (!start_i && phi_t_vld) begin
      if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
    end
  end

  // Register the outstanding-request count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  // Frame FSM with output index, done pulse and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_go) begin
            overflow_q <= 1'b0;
            if (frame_len != '0) begin
              len_q   <= frame_len;
              idx_q   <= '0;
              state_q <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en) begin
            if (last_beat) begin
              state_q <= LAST_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        LAST_DONE: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
      // A drop in the same cycle as a frame start still has to be reported.
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule
